matrix_loader: RTL

Upstream feeder for the 4x4 systolic multiplier top. Accepts a byte stream over a valid/ready handshake: 16 elements of A, then 16 elements of B, both row-major. It assembles them into the packed `o_a`/`o_b` matrices and pulses `o_validInput` for one cycle. It then blocks further input until the array reports `i_validResult`, so a new operand pair never corrupts a multiplication in flight.

---
 rtl/matrix_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/matrix_loader.sv
// Byte-stream loader for the NxN systolic multiplier: assembles A then B,
// issues them with a one-cycle strobe, and holds off input until the result returns.

module matrix_loader_cell #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_arst,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)    o_q <= '0;
        else if (i_we) o_q <= i_d;
    end
endmodule

module matrix_loader #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic [W-1:0]               i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_last,
    output logic [N-1:0][N-1:0][W-1:0] o_a,
    output logic [N-1:0][N-1:0][W-1:0] o_b,
    output logic                       o_validInput,
    input  logic                       i_validResult,
    output logic                       o_busy,
    output logic                       o_error
);
    localparam int ELEMS = N * N;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] ISSUE  = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             error_nxt;
    logic             accept, is_last_idx, frame_err;

    assign o_ready      = (state == LOAD_A) || (state == LOAD_B);
    assign o_busy       = (state == ISSUE) || (state == WAIT);
    assign o_validInput = (state == ISSUE);

    assign accept      = i_valid && o_ready;
    assign is_last_idx = (idx == LAST_IDX);
    // Only the final B beat may carry i_last; every other beat must not.
    assign frame_err   = ((state == LOAD_B) && is_last_idx) ? !i_last : i_last;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        error_nxt = 1'b0;
        case (state)
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (frame_err) begin
                        state_nxt = LOAD_A;
                        idx_nxt   = '0;
                        error_nxt = 1'b1;
                    end else if (is_last_idx) begin
                        state_nxt = (state == LOAD_A) ? LOAD_B : ISSUE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (i_validResult) begin
                    state_nxt = LOAD_A;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state   <= LOAD_A;
            idx     <= '0;
            o_error <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            o_error <= error_nxt;
        end
    end

    // One write-enabled cell per element; an errored beat still lands in its slot.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam logic [IDX_W-1:0] SLOT = IDX_W'(r * N + c);
            logic we_a, we_b;
            assign we_a = accept && (state == LOAD_A) && (idx == SLOT);
            assign we_b = accept && (state == LOAD_B) && (idx == SLOT);

            matrix_loader_cell #(.W(W)) u_cell_a (
                .i_clk  (i_clk),
                .i_arst (i_arst),
                .i_we   (we_a),
                .i_d    (i_data),
                .o_q    (o_a[r][c])
            );

            matrix_loader_cell #(.W(W)) u_cell_b (
                .i_clk  (i_clk),
                .i_arst (i_arst),
                .i_we   (we_b),
                .i_d    (i_data),
                .o_q    (o_b[r][c])
            );
        end
    end
endmodule
